grid_diff_tracker: RTL and testbench

- Parametrised successor to the fixed 16x12 snake frame tracker.
- Raster-scans a GRID_W x GRID_H cell grid, samples upstream object flags for the current cell and keeps a per-cell shadow of the last emitted object code.
- Emits only changed cells to the downstream pixel renderer over a valid/ready stream; the scan stalls while the renderer back-pressures.
- Sits between the game-state logic (which answers flags for out_x/out_y combinationally) and the renderer.

---
 rtl/grid_diff_tracker.sv | 197 +++++++++++++++++++
 tb/tb_grid_diff_tracker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_diff_tracker.sv
// Raster-scans a GRID_W x GRID_H grid and streams only cells whose object code changed since the last frame.
// Optional macro GRID_TRACKER_REFRESH_EN adds refresh_req, which forces one full-frame re-emit.
module grid_diff_tracker #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3,
  parameter int FCNT_W = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int DW = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              border,
  input  logic              body,
  input  logic              head,
  input  logic              apple,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [DW-1:0]     frame_diffs
`ifdef GRID_TRACKER_REFRESH_EN
  ,
  input  logic              refresh_req
`endif
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = $clog2(NCELL);

  localparam logic [CODE_W-1:0] C_BLANK  = CODE_W'(0);
  localparam logic [CODE_W-1:0] C_HEAD   = CODE_W'(1);
  localparam logic [CODE_W-1:0] C_BODY   = CODE_W'(2);
  localparam logic [CODE_W-1:0] C_APPLE  = CODE_W'(3);
  localparam logic [CODE_W-1:0] C_BORDER = CODE_W'(4);

  typedef enum logic {SCAN = 1'b0, EMIT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [DW-1:0]       fdiffs_q, fdiffs_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [CODE_W-1:0]   shadow_q [NCELL];

  logic [IW-1:0]       idx;
  logic                perim, last_x, last_y;
  logic [CODE_W-1:0]   desired;
  logic                force_emit;
  logic                shadow_we, advance, beat_done, wrap;

  assign idx    = IW'(int'(y_q) * GRID_W + int'(x_q));
  assign last_x = (x_q == XW'(GRID_W - 1));
  assign last_y = (y_q == YW'(GRID_H - 1));
  assign perim  = (x_q == '0) || last_x || (y_q == '0) || last_y;

  // Border wins only on the perimeter; interior border flags are ignored.
  always_comb begin
    desired = C_BLANK;
    if (border && perim) desired = C_BORDER;
    else if (body)       desired = C_BODY;
    else if (head)       desired = C_HEAD;
    else if (apple)      desired = C_APPLE;
  end

`ifdef GRID_TRACKER_REFRESH_EN
  logic pend_q, pend_d, armed_q, armed_d, arm_now;

  // A pending refresh arms only when the scan sits at the first cell, so the whole frame re-emits.
  assign arm_now    = pend_q && (state_q == SCAN) && (x_q == '0) && (y_q == '0);
  assign force_emit = armed_q || arm_now;
  assign pend_d     = refresh_req || (pend_q && !arm_now);
  assign armed_d    = (armed_q || arm_now) && !wrap;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      armed_q <= armed_d;
    end
  end
`else
  assign force_emit = 1'b0;
`endif

  // Output stream: a beat is transferred on a rising clk where out_valid && out_ready;
  // out_x/out_y/out_code/out_valid hold steady from assertion until that transfer.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    code_d       = code_q;
    frame_done_d = 1'b0;
    fcnt_d       = fcnt_q;
    fdiffs_d     = fdiffs_q;
    dcnt_d       = dcnt_q;
    shadow_we    = 1'b0;
    advance      = 1'b0;
    beat_done    = 1'b0;
    wrap         = 1'b0;

    case (state_q)
      SCAN: begin
        if (enable) begin
          if (force_emit || (desired != shadow_q[idx])) begin
            shadow_we = 1'b1;
            code_d    = desired;
            state_d   = EMIT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          advance   = 1'b1;
          beat_done = 1'b1;
          state_d   = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase

    if (advance) begin
      if (last_x) begin
        x_d = '0;
        if (last_y) begin
          y_d  = '0;
          wrap = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // The wrap beat itself belongs to the frame that just finished.
    if (wrap) begin
      frame_done_d = 1'b1;
      fcnt_d       = fcnt_q + 1'b1;
      fdiffs_d     = dcnt_q + DW'(beat_done);
      dcnt_d       = '0;
    end else if (beat_done) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= SCAN;
      x_q          <= '0;
      y_q          <= '0;
      code_q       <= '0;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
      fdiffs_q     <= '0;
      dcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      code_q       <= code_d;
      frame_done_q <= frame_done_d;
      fcnt_q       <= fcnt_d;
      fdiffs_q     <= fdiffs_d;
      dcnt_q       <= dcnt_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCELL; i++) shadow_q[i] <= C_BLANK;
    end else if (shadow_we) begin
      shadow_q[idx] <= desired;
    end
  end

  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_code    = code_q;
  assign out_valid   = (state_q == EMIT);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = fcnt_q;
  assign frame_diffs = fdiffs_q;

endmodule

// File: tb/tb_grid_diff_tracker.sv
// Self-checking bench for grid_diff_tracker: vector table, hand sequences and randomized frames
// checked against a frame-level reference model of the object grid.
module tb_grid_diff_tracker;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int CW = 3;
  localparam int FW = 8;
  localparam int XW = $clog2(GW);
  localparam int YW = $clog2(GH);
  localparam int DW = $clog2(GW * GH + 1);
  localparam int N  = GW * GH;
  localparam int BW = XW + YW + CW;
  localparam int BUDGET = 5000;

  // clock / reset
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic          enable, border, body, head, apple, out_valid, out_ready, frame_done;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_code;
  logic [FW-1:0] frame_cnt;
  logic [DW-1:0] frame_diffs;
  logic          refresh_req;

  grid_diff_tracker #(.GRID_W(GW), .GRID_H(GH), .CODE_W(CW), .FCNT_W(FW)) dut (
    .clk(clk), .nrst(nrst), .enable(enable),
    .border(border), .body(body), .head(head), .apple(apple),
    .out_x(out_x), .out_y(out_y), .out_code(out_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_diffs(frame_diffs)
`ifdef GRID_TRACKER_REFRESH_EN
    , .refresh_req(refresh_req)
`endif
  );

  // game-state world: flag maps answered combinationally for the DUT cursor
  bit bm [N];
  bit ym [N];
  bit hm [N];
  bit am [N];
  int cell_idx;

  always_comb begin
    cell_idx = int'(out_y) * GW + int'(out_x);
    border = 1'b0; body = 1'b0; head = 1'b0; apple = 1'b0;
    if (cell_idx < N) begin
      border = bm[cell_idx]; body = ym[cell_idx]; head = hm[cell_idx]; apple = am[cell_idx];
    end
  end

  // scoreboard
  logic [BW-1:0] exp_q[$];
  logic [CW-1:0] shadow_m [N];
  int tests = 0;
  int fails = 0;
  int exp_fcnt = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int x, input int y, input logic [CW-1:0] c);
    return {XW'(x), YW'(y), c};
  endfunction

  function automatic logic [CW-1:0] desired_m(input int x, input int y);
    int  i    = y * GW + x;
    bit  edge_c = (x == 0) || (x == GW - 1) || (y == 0) || (y == GH - 1);
    if (bm[i] && edge_c) return CW'(4);
    if (ym[i]) return CW'(2);
    if (hm[i]) return CW'(1);
    if (am[i]) return CW'(3);
    return CW'(0);
  endfunction

  // One frame of the reference: every changed (or, when forced, every) cell in raster order.
  task automatic build_expected(input bit force_all, output int n);
    logic [CW-1:0] d;
    n = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        d = desired_m(x, y);
        if (force_all || d != shadow_m[y * GW + x]) begin
          exp_q.push_back(pack(x, y, d));
          n++;
        end
        shadow_m[y * GW + x] = d;
      end
  endtask

  task automatic clear_world();
    for (int i = 0; i < N; i++) begin
      bm[i] = 1'b0; ym[i] = 1'b0; hm[i] = 1'b0; am[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0; enable = 1'b0; out_ready = 1'b0; refresh_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < N; i++) shadow_m[i] = '0;
    exp_q.delete();
    exp_fcnt = 0;
  endtask

  // driver + monitor for one frame; starts and ends at a negedge with the scan parked at (0,0)
  task automatic run_frame(input int en_pct, input int rdy_pct, input int refresh_at,
                           input int exp_diffs, output int cycles);
    int cyc = 0;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [BW-1:0] held, cur, e;
    held = '0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      refresh_req = (cyc == refresh_at);
      if (frame_done) begin
        done = 1'b1; enable = 1'b0; out_ready = 1'b0;
      end else begin
        cur = {out_x, out_y, out_code};
        if (stalled) check(out_valid && cur == held, "hold", 32'(cur), 32'(held));
        enable    = (int'($urandom_range(0, 99)) < en_pct);
        out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        stalled   = out_valid && !out_ready;
        held      = cur;
        if (out_valid && out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          check(cur == e, "beat", 32'(cur), 32'(e));
        end
      end
    end
    refresh_req = 1'b0;
    check(done, "frame_timeout", 32'(cyc), BUDGET);
    if (done) begin
      exp_fcnt = (exp_fcnt + 1) % (1 << FW);
      check(int'(frame_diffs) == exp_diffs, "frame_diffs", 32'(frame_diffs), 32'(exp_diffs));
      check(int'(frame_cnt) == exp_fcnt, "frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    end
    check(exp_q.size() == 0, "missing_beats", 32'(exp_q.size()), 0);
    exp_q.delete();
    cycles = cyc - 1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0; enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    check(ok, "valid_timeout", 32'(ok), 1);
  endtask

  typedef struct {
    int x; int y;
    bit b; bit bd; bit h; bit a;
    bit emits;
    logic [CW-1:0] code;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc, n;
    bit ok;
    logic [BW-1:0] e, cur;

    vecs[0]  = '{x:7,  y:7,  b:0, bd:1, h:1, a:0, emits:1, code:3'd2};
    vecs[1]  = '{x:0,  y:4,  b:1, bd:1, h:1, a:0, emits:1, code:3'd4};
    vecs[2]  = '{x:7,  y:7,  b:1, bd:0, h:0, a:0, emits:0, code:3'd0};
    vecs[3]  = '{x:7,  y:7,  b:1, bd:0, h:0, a:1, emits:1, code:3'd3};
    vecs[4]  = '{x:3,  y:5,  b:0, bd:0, h:1, a:1, emits:1, code:3'd1};
    vecs[5]  = '{x:15, y:11, b:0, bd:0, h:0, a:1, emits:1, code:3'd3};
    vecs[6]  = '{x:15, y:0,  b:1, bd:0, h:0, a:1, emits:1, code:3'd4};
    vecs[7]  = '{x:0,  y:0,  b:0, bd:0, h:1, a:0, emits:1, code:3'd1};
    vecs[8]  = '{x:2,  y:2,  b:0, bd:0, h:0, a:0, emits:0, code:3'd0};
    vecs[9]  = '{x:8,  y:0,  b:0, bd:1, h:0, a:1, emits:1, code:3'd2};
    vecs[10] = '{x:6,  y:11, b:1, bd:0, h:1, a:0, emits:1, code:3'd4};
    vecs[11] = '{x:14, y:1,  b:1, bd:0, h:1, a:0, emits:1, code:3'd1};

    nrst = 1'b0; enable = 1'b0; out_ready = 1'b0; refresh_req = 1'b0;
    clear_world();

    // reset values, while held and after release
    @(negedge clk);
    check(!out_valid && out_code == '0 && !frame_done, "reset_out", 32'({out_valid, out_code, frame_done}), 0);
    check(frame_cnt == '0 && frame_diffs == '0, "reset_cnt", 32'({frame_cnt, frame_diffs}), 0);
    do_reset();
    check(out_x == '0 && out_y == '0 && !out_valid, "reset_cursor", 32'({out_x, out_y, out_valid}), 0);

    // empty world: no beats, 192-cycle frames, single-cycle frame_done
    for (int f = 0; f < 2; f++) begin
      run_frame(100, 100, -1, 0, cyc);
      check(cyc == N, "empty_frame_cycles", 32'(cyc), N);
    end
    @(negedge clk);
    check(!frame_done, "frame_done_pulse", 32'(frame_done), 0);

    // vector table: one flagged cell per vector, checked over one frame from reset
    for (int v = 0; v < 12; v++) begin
      do_reset();
      clear_world();
      bm[vecs[v].y * GW + vecs[v].x] = vecs[v].b;
      ym[vecs[v].y * GW + vecs[v].x] = vecs[v].bd;
      hm[vecs[v].y * GW + vecs[v].x] = vecs[v].h;
      am[vecs[v].y * GW + vecs[v].x] = vecs[v].a;
      if (vecs[v].emits) exp_q.push_back(pack(vecs[v].x, vecs[v].y, vecs[v].code));
      run_frame(100, 100, -1, vecs[v].emits ? 1 : 0, cyc);
    end

    // border everywhere: 52 perimeter beats, then a quiet frame
    do_reset();
    clear_world();
    for (int i = 0; i < N; i++) bm[i] = 1'b1;
    build_expected(1'b0, n);
    run_frame(100, 100, -1, 52, cyc);
    check(cyc == N + 52, "border_frame_cycles", 32'(cyc), N + 52);
    build_expected(1'b0, n);
    run_frame(100, 100, -1, 0, cyc);
    check(cyc == N, "border_quiet_cycles", 32'(cyc), N);

    // reset while a beat is pending: dropped at once, borders re-emitted from (0,0)
    hm[3 * GW + 5] = 1'b1;
    build_expected(1'b0, n);
    wait_valid(ok);
    e = exp_q.pop_front();
    cur = {out_x, out_y, out_code};
    check(cur == e, "pre_reset_beat", 32'(cur), 32'(e));
    #2 nrst = 1'b0;
    #1 check(!out_valid && out_x == '0 && out_y == '0, "async_reset", 32'({out_valid, out_x, out_y}), 0);
    enable = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < N; i++) shadow_m[i] = '0;
    exp_q.delete();
    exp_fcnt = 0;
    build_expected(1'b0, n);
    run_frame(100, 100, -1, 53, cyc);

    // back-pressure on (5,3): beat held 4 cycles, cursor frozen, then moves to (6,3)
    do_reset();
    clear_world();
    repeat (5) @(negedge clk);
    check(out_x == '0 && out_y == '0 && !out_valid, "enable_low_hold", 32'({out_x, out_y, out_valid}), 0);
    hm[3 * GW + 5] = 1'b1;
    build_expected(1'b0, n);
    wait_valid(ok);
    e = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      cur = {out_x, out_y, out_code};
      check(out_valid && cur == e, "stall_beat", 32'(cur), 32'(e));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check(!out_valid && out_x == XW'(6) && out_y == YW'(3), "after_accept",
          32'({out_valid, out_x, out_y}), 32'({1'b0, XW'(6), YW'(3)}));
    run_frame(100, 100, -1, 1, cyc);
    hm[3 * GW + 5] = 1'b0;
    build_expected(1'b0, n);
    run_frame(100, 100, -1, n, cyc);

    // randomized frames with random enable / back-pressure
    do_reset();
    for (int f = 0; f < 6; f++) begin
      if (f != 3) begin
        for (int i = 0; i < N; i++) begin
          bm[i] = ($urandom_range(0, 3) == 0);
          ym[i] = ($urandom_range(0, 7) == 0);
          hm[i] = ($urandom_range(0, 15) == 0);
          am[i] = ($urandom_range(0, 7) == 0);
        end
      end
      build_expected(1'b0, n);
      run_frame(70, 60, -1, n, cyc);
    end

`ifdef GRID_TRACKER_REFRESH_EN
    // refresh request mid-frame: quiet until wrap, then a full 192-cell frame, then quiet
    build_expected(1'b0, n);
    run_frame(100, 100, 60, 0, cyc);
    build_expected(1'b1, n);
    run_frame(100, 100, -1, N, cyc);
    build_expected(1'b0, n);
    run_frame(100, 100, -1, 0, cyc);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
